// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the hardware stack controller: word width,
// default stack bounds and FSM state encoding.
package calc_stack_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] SP_TOP_DEF   = 16'h01FF;
  localparam logic [WORD_W-1:0] SP_LIMIT_DEF = 16'h0100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Plain vector constants so state registers stay legacy-compatible logic.
  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_WRITE  = 2'(WRITE);
  localparam logic [1:0] S_READ   = 2'(READ);
  localparam logic [1:0] S_FINISH = 2'(FINISH);

endpackage

// File: rtl/stack_ctrl_if.sv
// Request/response and memory-side signals of the stack controller.
interface stack_ctrl_if;
  import calc_stack_pkg::*;

  logic              push;
  logic              pop;
  logic [WORD_W-1:0] din;
  logic [WORD_W-1:0] dout;
  logic              busy;
  logic              done;
  logic              err;
  logic              full;
  logic              empty;
  logic [WORD_W-1:0] sp;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output push, pop, din, mem_rdata, mem_ack,
    input  dout, busy, done, err, full, empty, sp,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  push, pop, din, mem_rdata, mem_ack,
    output dout, busy, done, err, full, empty, sp,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/stack_ctrl_sp_counter.sv
// Stack pointer register with guarded increment/decrement and registered
// FULL/EMPTY flags derived from the next pointer value.
module sp_counter
  import calc_stack_pkg::*;
#(
  parameter logic [WORD_W-1:0] SP_TOP   = SP_TOP_DEF,
  parameter logic [WORD_W-1:0] SP_LIMIT = SP_LIMIT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              inc,
  input  logic              dec,
  output logic [WORD_W-1:0] sp,
  output logic              full,
  output logic              empty
);

  localparam logic [WORD_W-1:0] SP_FULL = SP_LIMIT - WORD_W'(1);

  logic [WORD_W-1:0] sp_reg;
  logic [WORD_W-1:0] sp_next;
  logic              full_reg;
  logic              empty_reg;

  // The flag guards keep the pointer inside [SP_LIMIT-1, SP_TOP].
  always_comb begin
    sp_next = sp_reg;
    if (inc && !empty_reg) begin
      sp_next = sp_reg + WORD_W'(1);
    end else if (dec && !full_reg) begin
      sp_next = sp_reg - WORD_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sp_reg    <= SP_TOP;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
    end else begin
      sp_reg    <= sp_next;
      full_reg  <= (sp_next == SP_FULL);
      empty_reg <= (sp_next == SP_TOP);
    end
  end

  assign sp    = sp_reg;
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/stack_ctrl.sv
// Hardware stack controller: accepts push/pop requests and sequences a
// single memory write or read with a handshake, tracking the stack pointer.
module stack_ctrl
  import calc_stack_pkg::*;
#(
  parameter logic [WORD_W-1:0] SP_TOP   = SP_TOP_DEF,
  parameter logic [WORD_W-1:0] SP_LIMIT = SP_LIMIT_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  stack_ctrl_if.slave  bus
);

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [WORD_W-1:0] addr_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic [WORD_W-1:0] dout_reg;
  logic              err_reg;

  logic              sp_inc;
  logic              sp_dec;
  logic [WORD_W-1:0] sp;
  logic              full;
  logic              empty;

  logic              push_ok;
  logic              pop_ok;
  logic              req_bad;

  assign push_ok = bus.push && !bus.pop && !full;
  assign pop_ok  = bus.pop && !bus.push && !empty;
  assign req_bad = (bus.push || bus.pop) && !push_ok && !pop_ok;

  always_comb begin
    state_next = state_reg;
    sp_inc     = 1'b0;
    sp_dec     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (push_ok) begin
          state_next = S_WRITE;
        end else if (pop_ok) begin
          state_next = S_READ;
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          sp_dec     = 1'b1;
          state_next = S_FINISH;
        end
      end
      S_READ: begin
        if (bus.mem_ack) begin
          sp_inc     = 1'b1;
          state_next = S_FINISH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Requests are only looked at in IDLE, so activity while busy is silently dropped.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      dout_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= (state_reg == S_IDLE) && req_bad;
      if (state_reg == S_IDLE) begin
        if (push_ok) begin
          addr_reg  <= sp;
          wdata_reg <= bus.din;
        end else if (pop_ok) begin
          addr_reg <= sp + WORD_W'(1);
        end
      end
      if ((state_reg == S_READ) && bus.mem_ack) begin
        dout_reg <= bus.mem_rdata;
      end
    end
  end

  sp_counter #(
    .SP_TOP   (SP_TOP),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp_counter (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  // Strobes decode straight from the state so an async reset drops them at once.
  assign bus.mem_we    = (state_reg == S_WRITE);
  assign bus.mem_re    = (state_reg == S_READ);
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.done      = (state_reg == S_FINISH);
  assign bus.err       = err_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.dout      = dout_reg;
  assign bus.sp        = sp;
  assign bus.full      = full;
  assign bus.empty     = empty;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed vectors, hand-built corner
// sequences and random traffic against a queue-based stack model.
module tb_stack_ctrl;

  localparam logic [15:0] TOP   = 16'h01FF;
  localparam int          DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_ctrl_if bus ();

  stack_ctrl #(
    .SP_TOP   (TOP),
    .SP_LIMIT (16'h0100)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] model_q [$];
  logic [15:0] last_dout;

  logic        r_done, r_err, r_we, r_re;
  logic [15:0] r_addr, r_wdata, r_dout;
  int          r_strobe_cycles;

  typedef struct {
    logic        push;
    logic        pop;
    logic [15:0] din;
    logic        e_done;
    logic        e_err;
    logic        e_we;
    logic        e_re;
    logic [15:0] e_addr;
    logic [15:0] e_data;
    logic [15:0] e_sp;
    logic        e_empty;
  } vec_t;

  vec_t tbl [8];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay extra strobe cycles.
  initial begin
    int cnt;
    cnt           = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.mem_we || bus.mem_re) begin
        if (cnt >= ack_delay) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem[bus.mem_addr];
          cnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        cnt         = 0;
      end
    end
  end

  // One request cycle, then observe until DONE or ERR (bounded).
  task automatic run_op(input logic p, input logic q, input logic [15:0] d);
    @(negedge clk);
    bus.push = p;
    bus.pop  = q;
    bus.din  = d;
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    r_done = 1'b0; r_err = 1'b0; r_we = 1'b0; r_re = 1'b0;
    r_addr = 16'h0000; r_wdata = 16'h0000; r_dout = 16'h0000;
    r_strobe_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.mem_we || bus.mem_re) begin
        r_strobe_cycles++;
        r_addr = bus.mem_addr;
        if (bus.mem_we) begin
          r_we    = 1'b1;
          r_wdata = bus.mem_wdata;
        end
        if (bus.mem_re) r_re = 1'b1;
      end
      if (bus.done) begin
        r_done = 1'b1;
        r_dout = bus.dout;
        break;
      end
      if (bus.err) begin
        r_err = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic model_op(input logic p, input logic q, input logic [15:0] d);
    int          size;
    logic        do_push, do_pop;
    logic [15:0] exp_addr, exp_val;
    size    = model_q.size();
    do_push = p && !q && (size < DEPTH);
    do_pop  = q && !p && (size > 0);
    exp_addr = 16'h0000;
    exp_val  = 16'h0000;
    chk16("dout_hold", bus.dout, last_dout);
    run_op(p, q, d);
    if (do_push) begin
      exp_addr = TOP - 16'(size);
      model_q.push_back(d);
    end else if (do_pop) begin
      exp_addr  = TOP - 16'(size) + 16'd1;
      exp_val   = model_q.pop_back();
      last_dout = exp_val;
    end
    chk1("op_done", r_done, do_push || do_pop);
    chk1("op_err", r_err, !(do_push || do_pop));
    chk1("op_we", r_we, do_push);
    chk1("op_re", r_re, do_pop);
    if (do_push) begin
      chk16("push_addr", r_addr, exp_addr);
      chk16("push_wdata", r_wdata, d);
    end
    if (do_pop) begin
      chk16("pop_addr", r_addr, exp_addr);
      chk16("pop_dout", r_dout, exp_val);
    end
    chk16("op_sp", bus.sp, TOP - 16'(model_q.size()));
    chk1("op_full", bus.full, model_q.size() == DEPTH);
    chk1("op_empty", bus.empty, model_q.size() == 0);
    $display("op push=%0b pop=%0b din=%h done=%0b err=%0b addr=%h sp=%h depth=%0d",
             p, q, d, r_done, r_err, r_addr, bus.sp, model_q.size());
  endtask

  initial begin
    int we_cyc, busy_low, dones, errs, r;
    logic seen_done;

    tbl[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h01FF, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h01FF, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 16'hABCD, 1'b1, 1'b0, 1'b1, 1'b0, 16'h01FF, 16'hABCD, 16'h01FE, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h01FF, 16'hABCD, 16'h01FF, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, 1'b1, 1'b0, 16'h01FF, 16'h1111, 16'h01FE, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 16'h01FE, 16'h2222, 16'h01FD, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h01FE, 16'h2222, 16'h01FE, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h01FF, 16'h1111, 16'h01FF, 1'b1};

    bus.push = 1'b0; bus.pop = 1'b0; bus.din = 16'h0000;
    rst = 1'b0;
    last_dout = 16'h0000;
    repeat (3) @(negedge clk);
    chk16("rst_sp", bus.sp, TOP);
    chk1("rst_empty", bus.empty, 1'b1);
    chk1("rst_full", bus.full, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chk1("rst_we", bus.mem_we, 1'b0);
    chk1("rst_re", bus.mem_re, 1'b0);
    chk16("rst_dout", bus.dout, 16'h0000);
    chk16("rst_addr", bus.mem_addr, 16'h0000);
    chk16("rst_wdata", bus.mem_wdata, 16'h0000);
    $display("reset sp=%h empty=%0b", bus.sp, bus.empty);
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].push, tbl[i].pop, tbl[i].din);
      chk1("vec_done", r_done, tbl[i].e_done);
      chk1("vec_err", r_err, tbl[i].e_err);
      chk1("vec_we", r_we, tbl[i].e_we);
      chk1("vec_re", r_re, tbl[i].e_re);
      if (tbl[i].e_we || tbl[i].e_re) chk16("vec_addr", r_addr, tbl[i].e_addr);
      if (tbl[i].e_we) chk16("vec_wdata", r_wdata, tbl[i].e_data);
      if (tbl[i].e_re) chk16("vec_dout", r_dout, tbl[i].e_data);
      if (tbl[i].e_done) chki("vec_strobe_cycles", r_strobe_cycles, 1);
      chk16("vec_sp", bus.sp, tbl[i].e_sp);
      chk1("vec_empty", bus.empty, tbl[i].e_empty);
      chk1("vec_full", bus.full, 1'b0);
      $display("vec %0d push=%0b pop=%0b din=%h done=%0b err=%0b addr=%h sp=%h",
               i, tbl[i].push, tbl[i].pop, tbl[i].din, r_done, r_err, r_addr, bus.sp);
    end
    last_dout = 16'h1111;

    // Delayed ACK: strobe held 5 cycles, PUSH during BUSY ignored
    ack_delay = 4;
    @(negedge clk);
    bus.push = 1'b1; bus.din = 16'h5A5A;
    @(negedge clk);
    bus.push = 1'b0;
    we_cyc = 0; busy_low = 0; dones = 0; errs = 0; seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.mem_we) we_cyc++;
      if (bus.mem_we && bus.mem_re) errs++;
      if (!seen_done && !bus.busy) busy_low++;
      if (bus.done) begin dones++; seen_done = 1'b1; end
      if (bus.err) errs++;
      if (i == 2) begin bus.push = 1'b1; bus.din = 16'hDEAD; end
      else bus.push = 1'b0;
      @(negedge clk);
    end
    chki("slow_we_cycles", we_cyc, 5);
    chki("slow_busy_gaps", busy_low, 0);
    chki("slow_done_count", dones, 1);
    chki("slow_err_count", errs, 0);
    chk16("slow_sp", bus.sp, 16'h01FE);
    model_q.push_back(16'h5A5A);
    $display("slow push we_cycles=%0d dones=%0d sp=%h", we_cyc, dones, bus.sp);
    ack_delay = 0;
    model_op(1'b0, 1'b1, 16'h0000);

    // Fill to FULL, then one rejected push
    for (int i = 0; i < DEPTH; i++) model_op(1'b1, 1'b0, 16'(i * 37 + 3));
    chk16("full_sp", bus.sp, 16'h00FF);
    chk1("full_flag", bus.full, 1'b1);
    model_op(1'b1, 1'b0, 16'hBEEF);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      ack_delay = $urandom_range(0, 3);
      r = $urandom_range(0, 19);
      if (r < 9) model_op(1'b1, 1'b0, 16'($urandom));
      else if (r < 18) model_op(1'b0, 1'b1, 16'($urandom));
      else model_op(1'b1, 1'b1, 16'($urandom));
    end

    // Reset during READ
    ack_delay = 0;
    if (model_q.size() == 0) model_op(1'b1, 1'b0, 16'h7777);
    ack_delay = 3;
    @(negedge clk);
    bus.pop = 1'b1;
    @(negedge clk);
    bus.pop = 1'b0;
    chk1("abort_re_before", bus.mem_re, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("abort_re", bus.mem_re, 1'b0);
    chk1("abort_busy", bus.busy, 1'b0);
    chk16("abort_sp", bus.sp, 16'h01FF);
    chk1("abort_empty", bus.empty, 1'b1);
    chk16("abort_dout", bus.dout, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    chki("abort_no_done", dones, 0);
    $display("abort read sp=%h dones=%0d", bus.sp, dones);
    model_q.delete();
    last_dout = 16'h0000;
    ack_delay = 0;
    model_op(1'b1, 1'b0, 16'hC0DE);
    model_op(1'b0, 1'b1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter SP_TOP, default 16'h01FF, empty-stack pointer value and highest stack address.
REQ-002 Parameter SP_LIMIT, default 16'h0100, lowest writable stack address (depth = SP_TOP-SP_LIMIT+1 = 256).
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 PUSH  input  1  push request, sampled in IDLE only.
REQ-006 POP  input  1  pop request, sampled in IDLE only.
REQ-007 DIN  input  16  push data, captured with PUSH.
REQ-008 DOUT  output  16  popped data, valid while DONE=1 and held until the next pop completes.
REQ-009 BUSY  output  1  high while an operation is in progress.
REQ-010 DONE  output  1  one-cycle pulse on operation completion.
REQ-011 ERR  output  1  one-cycle pulse on a rejected request.
REQ-012 FULL  output  1  high when SP == SP_LIMIT-1.
REQ-013 EMPTY  output  1  high when SP == SP_TOP.
REQ-014 SP  output  16  current stack pointer (next free slot).
REQ-015 MEM_ADDR  output  16  memory address.
REQ-016 MEM_WDATA  output  16  memory write data.
REQ-017 MEM_WE  output  1  memory write strobe, held until MEM_ACK.
REQ-018 MEM_RE  output  1  memory read strobe, held until MEM_ACK.
REQ-019 MEM_RDATA  input  16  memory read data, valid in the MEM_ACK cycle.
REQ-020 MEM_ACK  input  1  memory completion, one or more cycles after the strobe.

Function
REQ-021 The FSM SHALL have the states IDLE, WRITE, READ and FINISH.
REQ-022 In IDLE, PUSH=1 with POP=0 and FULL=0 SHALL capture DIN and MEM_ADDR<=SP, then go to WRITE.
REQ-023 In IDLE, POP=1 with PUSH=0 and EMPTY=0 SHALL set MEM_ADDR<=SP+1, then go to READ.
REQ-024 In IDLE, the following SHALL pulse ERR the next cycle, leave SP unchanged and stay in IDLE: PUSH with FULL=1, POP with EMPTY=1, or PUSH and POP both high.
REQ-025 WRITE SHALL drive MEM_WE=1 and MEM_WDATA=captured DIN; on MEM_ACK=1 it SHALL set SP<=SP-1 and go to FINISH.
REQ-026 READ SHALL drive MEM_RE=1; on MEM_ACK=1 it SHALL set DOUT<=MEM_RDATA and SP<=SP+1, then go to FINISH.
REQ-027 FINISH SHALL pulse DONE for exactly one cycle and return to IDLE.
REQ-028 BUSY SHALL be 1 in WRITE, READ and FINISH, and 0 in IDLE.
REQ-029 Minimum latency SHALL be: request in cycle N; strobe in N+1; ACK in N+1; DONE in N+2; a new request is accepted in N+3.
REQ-030 PUSH and POP SHALL be ignored while BUSY=1, without raising ERR.
REQ-031 SP arithmetic SHALL be 16-bit unsigned, and SP SHALL never leave the range [SP_LIMIT-1, SP_TOP].
REQ-032 FULL, EMPTY and SP SHALL be registered outputs that reflect the updated SP in the cycle after the ACK.
REQ-033 MEM_WE and MEM_RE SHALL never be high together, and both SHALL be 0 in IDLE and FINISH.

Reset
REQ-034 RST=0 SHALL immediately force: state=IDLE, SP=SP_TOP, EMPTY=1, FULL=0, DOUT=0, MEM_ADDR=0, MEM_WDATA=0, and BUSY, DONE, ERR, MEM_WE, MEM_RE all 0.
REQ-035 Reset asserted during WRITE or READ SHALL abort the operation without an SP update, drop the strobe in the same instant, and produce no DONE.

Structure
REQ-036 A shared package calc_stack_pkg SHALL hold the FSM state enum, the SP_TOP and SP_LIMIT defaults, and the 16-bit word width constant.
REQ-037 The SP register, with its increment, decrement and FULL/EMPTY compare, SHALL be one sub-module, sp_counter, controlled by stack_ctrl.

Verification
REQ-038 Reset, then PUSH DIN=16'hABCD with ACK one cycle after WE -> MEM_ADDR=16'h01FF, MEM_WDATA=16'hABCD, DONE pulse, SP=16'h01FE, EMPTY=0.
REQ-039 Push 16'h1111 then 16'h2222, then pop twice -> DOUT=16'h2222 from address 16'h01FE, then DOUT=16'h1111 from address 16'h01FF; SP=16'h01FF and EMPTY=1.
REQ-040 POP after reset -> ERR pulse, no MEM_RE, SP=16'h01FF; PUSH and POP high together -> ERR pulse, no strobe.
REQ-041 256 pushes -> FULL=1 with SP=16'h00FF; a 257th PUSH -> ERR pulse and no MEM_WE.
REQ-042 MEM_ACK delayed 5 cycles -> MEM_WE held 5 cycles, BUSY high throughout, a PUSH pulse during BUSY is ignored, and DONE pulses once.
REQ-043 RST low during READ -> MEM_RE=0 immediately, SP=16'h01FF, no DONE after release.
